// File: rtl/id_ex_if.sv
// Decode-to-execute bundle for the ID/EX register: decoded fields in,
// registered fields out, plus the load-use stall and bubble counter.
interface id_ex_if #(
    parameter int CNT_W = 32
);
    logic             mem_stall_i;
    logic             MemWrite_i, MemRead_i, MemToReg_i, ALUSrc_i, RegWrite_i;
    logic [1:0]       ALUOp_i;
    logic [31:0]      RS1data_i, RS2data_i, Imm_i;
    logic [9:0]       Funct_i;
    logic [4:0]       RS1addr_i, RS2addr_i, RDaddr_i;

    logic             MemWrite_o, MemRead_o, MemToReg_o, ALUSrc_o, RegWrite_o;
    logic [1:0]       ALUOp_o;
    logic [31:0]      RS1data_o, RS2data_o, Imm_o;
    logic [9:0]       Funct_o;
    logic [4:0]       RS1addr_o, RS2addr_o, RDaddr_o;
    logic             Stall_o, PCWrite_o;
    logic [CNT_W-1:0] bubble_cnt_o;

    modport master (
        output mem_stall_i, MemWrite_i, MemRead_i, MemToReg_i, ALUSrc_i, RegWrite_i,
               ALUOp_i, RS1data_i, RS2data_i, Imm_i, Funct_i, RS1addr_i, RS2addr_i,
               RDaddr_i,
        input  MemWrite_o, MemRead_o, MemToReg_o, ALUSrc_o, RegWrite_o, ALUOp_o,
               RS1data_o, RS2data_o, Imm_o, Funct_o, RS1addr_o, RS2addr_o, RDaddr_o,
               Stall_o, PCWrite_o, bubble_cnt_o
    );

    modport slave (
        input  mem_stall_i, MemWrite_i, MemRead_i, MemToReg_i, ALUSrc_i, RegWrite_i,
               ALUOp_i, RS1data_i, RS2data_i, Imm_i, Funct_i, RS1addr_i, RS2addr_i,
               RDaddr_i,
        output MemWrite_o, MemRead_o, MemToReg_o, ALUSrc_o, RegWrite_o, ALUOp_o,
               RS1data_o, RS2data_o, Imm_o, Funct_o, RS1addr_o, RS2addr_o, RDaddr_o,
               Stall_o, PCWrite_o, bubble_cnt_o
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection: one bubble per
// dependency on a load still in EX, full hold while the memory stage stalls.
module id_ex_stage #(
    parameter int CNT_W = 32
) (
    input  logic   clk_i,
    input  logic   rst_i,
    id_ex_if.slave bus
);
    typedef struct packed {
        logic       mem_write;
        logic       mem_read;
        logic       mem_to_reg;
        logic       alu_src;
        logic       reg_write;
        logic [1:0] alu_op;
    } ctrl_t;

    typedef struct packed {
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [9:0]  funct;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [4:0]  rd_addr;
    } data_t;

    ctrl_t            ctrl_in, ctrl_d, ctrl_q;
    data_t            data_in, data_d, data_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             use_rs2;
    logic             hazard;

    assign ctrl_in = {bus.MemWrite_i, bus.MemRead_i, bus.MemToReg_i, bus.ALUSrc_i,
                      bus.RegWrite_i, bus.ALUOp_i};
    assign data_in = {bus.RS1data_i, bus.RS2data_i, bus.Imm_i, bus.Funct_i,
                      bus.RS1addr_i, bus.RS2addr_i, bus.RDaddr_i};

    // R-type, branch and store read rs2; an immediate-form non-store does not.
    assign use_rs2 = ~bus.ALUSrc_i | bus.MemWrite_i;
    assign hazard  = ctrl_q.mem_read && (data_q.rd_addr != 5'd0) &&
                     ((data_q.rd_addr == bus.RS1addr_i) ||
                      (use_rs2 && (data_q.rd_addr == bus.RS2addr_i)));

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        ctrl_d = ctrl_q;
        data_d = data_q;
        cnt_d  = cnt_q;
        if (!bus.mem_stall_i) begin
            data_d = data_in;
            if (hazard) begin
                ctrl_d = '0;
                if (!(&cnt_q)) cnt_d = cnt_q + CNT_W'(1);
            end else begin
                ctrl_d = ctrl_in;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_i) begin
            ctrl_q <= '0;
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.MemWrite_o   = ctrl_q.mem_write;
    assign bus.MemRead_o    = ctrl_q.mem_read;
    assign bus.MemToReg_o   = ctrl_q.mem_to_reg;
    assign bus.ALUSrc_o     = ctrl_q.alu_src;
    assign bus.RegWrite_o   = ctrl_q.reg_write;
    assign bus.ALUOp_o      = ctrl_q.alu_op;
    assign bus.RS1data_o    = data_q.rs1_data;
    assign bus.RS2data_o    = data_q.rs2_data;
    assign bus.Imm_o        = data_q.imm;
    assign bus.Funct_o      = data_q.funct;
    assign bus.RS1addr_o    = data_q.rs1_addr;
    assign bus.RS2addr_o    = data_q.rs2_addr;
    assign bus.RDaddr_o     = data_q.rd_addr;
    assign bus.Stall_o      = hazard;
    assign bus.PCWrite_o    = ~hazard;
    assign bus.bubble_cnt_o = cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: an instruction-level model compared on
// every falling edge, plus directed load-use, stall, x0, reset and saturation cases.
module tb_id_ex_stage;
    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    always #5 clk_i = ~clk_i;

    id_ex_if #(.CNT_W(32)) b  ();
    id_ex_if #(.CNT_W(2))  b2 ();

    id_ex_stage #(.CNT_W(32)) dut  (.clk_i(clk_i), .rst_i(rst_i), .bus(b.slave));
    id_ex_stage #(.CNT_W(2))  dut2 (.clk_i(clk_i), .rst_i(rst_i), .bus(b2.slave));

    // The narrow-counter copy sees exactly the same stimulus.
    assign b2.mem_stall_i = b.mem_stall_i;
    assign b2.MemWrite_i  = b.MemWrite_i;
    assign b2.MemRead_i   = b.MemRead_i;
    assign b2.MemToReg_i  = b.MemToReg_i;
    assign b2.ALUSrc_i    = b.ALUSrc_i;
    assign b2.RegWrite_i  = b.RegWrite_i;
    assign b2.ALUOp_i     = b.ALUOp_i;
    assign b2.RS1data_i   = b.RS1data_i;
    assign b2.RS2data_i   = b.RS2data_i;
    assign b2.Imm_i       = b.Imm_i;
    assign b2.Funct_i     = b.Funct_i;
    assign b2.RS1addr_i   = b.RS1addr_i;
    assign b2.RS2addr_i   = b.RS2addr_i;
    assign b2.RDaddr_i    = b.RDaddr_i;

    typedef struct packed {
        logic        mw, mr, mtr, as, rw;
        logic [1:0]  op;
        logic [31:0] d1, d2, imm;
        logic [9:0]  f;
        logic [4:0]  a1, a2, rd;
    } instr_t;

    int     n_vec = 0;
    int     n_bad = 0;
    instr_t cur   = '0;
    instr_t m     = '0;
    longint unsigned m_cnt  = 0;
    int              m_cnt2 = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic instr_t r_add(input logic [4:0] rd, input logic [4:0] rs1,
                                     input logic [4:0] rs2, input logic [31:0] v1,
                                     input logic [31:0] v2);
        instr_t i = '0;
        i.rw = 1'b1; i.op = 2'b10; i.rd = rd; i.a1 = rs1; i.a2 = rs2; i.d1 = v1; i.d2 = v2;
        return i;
    endfunction

    function automatic instr_t ld(input logic [4:0] rd, input logic [4:0] rs1);
        instr_t i = '0;
        i.mr = 1'b1; i.mtr = 1'b1; i.as = 1'b1; i.rw = 1'b1; i.rd = rd; i.a1 = rs1;
        i.d1 = 32'h1000; i.imm = 32'h4; i.f = 10'h002;
        return i;
    endfunction

    function automatic instr_t addi(input logic [4:0] rd, input logic [4:0] rs1,
                                    input logic [4:0] rs2_field, input logic [31:0] imm);
        instr_t i = '0;
        i.as = 1'b1; i.rw = 1'b1; i.op = 2'b10; i.rd = rd; i.a1 = rs1; i.a2 = rs2_field;
        i.imm = imm;
        return i;
    endfunction

    function automatic instr_t st(input logic [4:0] rs1, input logic [4:0] rs2);
        instr_t i = '0;
        i.mw = 1'b1; i.as = 1'b1; i.a1 = rs1; i.a2 = rs2; i.f = 10'h002; i.d2 = 32'hCAFE;
        return i;
    endfunction

    // Load-use rule from the decoded fields of the EX and ID instructions.
    function automatic logic model_hazard(input instr_t ex, input instr_t id);
        logic reads_rs2;
        reads_rs2 = !id.as || id.mw;
        return ex.mr && (ex.rd != 0) && ((ex.rd == id.a1) || (reads_rs2 && (ex.rd == id.a2)));
    endfunction

    task automatic apply(input instr_t i);
        cur          = i;
        b.MemWrite_i = i.mw;  b.MemRead_i = i.mr;  b.MemToReg_i = i.mtr;
        b.ALUSrc_i   = i.as;  b.RegWrite_i = i.rw; b.ALUOp_i = i.op;
        b.RS1data_i  = i.d1;  b.RS2data_i = i.d2;  b.Imm_i = i.imm;
        b.Funct_i    = i.f;   b.RS1addr_i = i.a1;  b.RS2addr_i = i.a2;
        b.RDaddr_i   = i.rd;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            m = '0; m_cnt = 0; m_cnt2 = 0;
        end else if (!b.mem_stall_i) begin
            if (model_hazard(m, cur)) begin
                m = cur;
                {m.mw, m.mr, m.mtr, m.as, m.rw, m.op} = '0;
                if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
                if (m_cnt2 < 3) m_cnt2++;
            end else begin
                m = cur;
            end
        end
    end

    always @(negedge clk_i) begin
        logic hz;
        hz = rst_i ? model_hazard(m, cur) : 1'b0;
        check("MemWrite_o", 64'(b.MemWrite_o), 64'(m.mw));
        check("MemRead_o",  64'(b.MemRead_o),  64'(m.mr));
        check("MemToReg_o", 64'(b.MemToReg_o), 64'(m.mtr));
        check("ALUSrc_o",   64'(b.ALUSrc_o),   64'(m.as));
        check("RegWrite_o", 64'(b.RegWrite_o), 64'(m.rw));
        check("ALUOp_o",    64'(b.ALUOp_o),    64'(m.op));
        check("RS1data_o",  64'(b.RS1data_o),  64'(m.d1));
        check("RS2data_o",  64'(b.RS2data_o),  64'(m.d2));
        check("Imm_o",      64'(b.Imm_o),      64'(m.imm));
        check("Funct_o",    64'(b.Funct_o),    64'(m.f));
        check("RS1addr_o",  64'(b.RS1addr_o),  64'(m.a1));
        check("RS2addr_o",  64'(b.RS2addr_o),  64'(m.a2));
        check("RDaddr_o",   64'(b.RDaddr_o),   64'(m.rd));
        check("Stall_o",    64'(b.Stall_o),    64'(hz));
        check("PCWrite_o",  64'(b.PCWrite_o),  64'(!hz));
        check("bubble_cnt", 64'(b.bubble_cnt_o),  m_cnt);
        check("bubble_cnt2", 64'(b2.bubble_cnt_o), 64'(m_cnt2));
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time budget");
        $fatal(1, "timeout");
    end

    initial begin
        b.mem_stall_i = 1'b0;
        apply('0);
        repeat (2) @(posedge clk_i);
        #3 rst_i = 1'b1;

        // Asynchronous reset with nonzero contents and inputs
        apply(r_add(5'd3, 5'd1, 5'd2, 32'h11, 32'h22));
        tick(); tick();
        apply(ld(5'd9, 5'd4));
        #2 rst_i = 1'b0;
        #1;
        check("rst_RegWrite", 64'(b.RegWrite_o), 64'd0);
        check("rst_RS1data",  64'(b.RS1data_o),  64'd0);
        check("rst_RDaddr",   64'(b.RDaddr_o),   64'd0);
        check("rst_Stall",    64'(b.Stall_o),    64'd0);
        check("rst_PCWrite",  64'(b.PCWrite_o),  64'd1);
        check("rst_cnt",      64'(b.bubble_cnt_o), 64'd0);
        #2 rst_i = 1'b1;
        tick();
        check("first_edge_RDaddr",  64'(b.RDaddr_o),  64'd9);
        check("first_edge_MemRead", 64'(b.MemRead_o), 64'd1);

        // Pass-through: add x3,x1,x2
        apply(r_add(5'd3, 5'd1, 5'd2, 32'h11, 32'h22));
        tick();
        check("pt_RegWrite", 64'(b.RegWrite_o), 64'd1);
        check("pt_ALUOp",    64'(b.ALUOp_o),    64'd2);
        check("pt_RS1data",  64'(b.RS1data_o),  64'h11);
        check("pt_RS2data",  64'(b.RS2data_o),  64'h22);
        check("pt_RDaddr",   64'(b.RDaddr_o),   64'd3);
        check("pt_Stall",    64'(b.Stall_o),    64'd0);

        // Load-use: lw x5 then add x6,x5,x7
        apply(ld(5'd5, 5'd1));
        tick();
        apply(r_add(5'd6, 5'd5, 5'd7, 32'h55, 32'h77));
        #1;
        check("lu_Stall",   64'(b.Stall_o),   64'd1);
        check("lu_PCWrite", 64'(b.PCWrite_o), 64'd0);
        tick();
        check("lu_bub_MemRead",  64'(b.MemRead_o),  64'd0);
        check("lu_bub_RegWrite", 64'(b.RegWrite_o), 64'd0);
        check("lu_bub_MemToReg", 64'(b.MemToReg_o), 64'd0);
        check("lu_bub_Stall",    64'(b.Stall_o),    64'd0);
        check("lu_cnt",          64'(b.bubble_cnt_o), 64'd1);
        tick();
        check("lu_add_RDaddr",   64'(b.RDaddr_o),   64'd6);
        check("lu_add_RS1addr",  64'(b.RS1addr_o),  64'd5);
        check("lu_add_RegWrite", 64'(b.RegWrite_o), 64'd1);

        // rs2 gating: addi with rs2 field = 5 does not stall
        apply(ld(5'd5, 5'd1));
        tick();
        apply(addi(5'd6, 5'd1, 5'd5, 32'd5));
        #1;
        check("addi_no_stall", 64'(b.Stall_o), 64'd0);
        tick();

        // sw x5,0(x1) after lw x5 stalls on rs2
        apply(ld(5'd5, 5'd1));
        tick();
        apply(st(5'd1, 5'd5));
        #1;
        check("sw_stall", 64'(b.Stall_o), 64'd1);
        tick();
        check("sw_cnt",  64'(b.bubble_cnt_o),  64'd2);
        check("sw_cnt2", 64'(b2.bubble_cnt_o), 64'd2);
        tick();
        check("sw_MemWrite", 64'(b.MemWrite_o), 64'd1);

        // lw x0 never creates a hazard
        apply(ld(5'd0, 5'd1));
        tick();
        apply(r_add(5'd6, 5'd0, 5'd0, 32'h0, 32'h0));
        #1;
        check("x0_no_stall", 64'(b.Stall_o), 64'd0);
        tick();

        // Memory stall overlapping a load-use hazard
        apply(ld(5'd5, 5'd1));
        tick();
        apply(r_add(5'd6, 5'd5, 5'd7, 32'h56, 32'h78));
        b.mem_stall_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("ms_Stall",   64'(b.Stall_o),      64'd1);
            check("ms_MemRead", 64'(b.MemRead_o),    64'd1);
            check("ms_RDaddr",  64'(b.RDaddr_o),     64'd5);
            check("ms_cnt",     64'(b.bubble_cnt_o), 64'd2);
        end
        b.mem_stall_i = 1'b0;
        tick();
        check("ms_bub_MemRead", 64'(b.MemRead_o),    64'd0);
        check("ms_bub_cnt",     64'(b.bubble_cnt_o), 64'd3);
        tick();
        check("ms_add_RDaddr",  64'(b.RDaddr_o),     64'd6);

        // Back-to-back: lw x5; lw x6,0(x5); add x7,x6,x6
        apply(ld(5'd5, 5'd1));
        tick();
        apply(ld(5'd6, 5'd5));
        #1;
        check("b2b_stall1", 64'(b.Stall_o), 64'd1);
        tick();
        tick();
        apply(r_add(5'd7, 5'd6, 5'd6, 32'h1, 32'h2));
        #1;
        check("b2b_stall2", 64'(b.Stall_o), 64'd1);
        tick();
        tick();
        check("b2b_cnt",  64'(b.bubble_cnt_o),  64'd5);
        check("sat_cnt2", 64'(b2.bubble_cnt_o), 64'd3);

        // Reset asserted in the middle of a memory stall with a pending hazard
        apply(ld(5'd5, 5'd1));
        tick();
        apply(r_add(5'd6, 5'd5, 5'd7, 32'h9, 32'hA));
        b.mem_stall_i = 1'b1;
        tick();
        #2 rst_i = 1'b0;
        #1;
        check("mrst_Stall",   64'(b.Stall_o),       64'd0);
        check("mrst_PCWrite", 64'(b.PCWrite_o),     64'd1);
        check("mrst_MemRead", 64'(b.MemRead_o),     64'd0);
        check("mrst_RDaddr",  64'(b.RDaddr_o),      64'd0);
        check("mrst_cnt",     64'(b.bubble_cnt_o),  64'd0);
        check("mrst_cnt2",    64'(b2.bubble_cnt_o), 64'd0);
        #2 rst_i = 1'b1;
        b.mem_stall_i = 1'b0;
        apply(r_add(5'd3, 5'd1, 5'd2, 32'h11, 32'h22));
        tick();
        check("mrst_load_RDaddr",   64'(b.RDaddr_o),   64'd3);
        check("mrst_load_RegWrite", 64'(b.RegWrite_o), 64'd1);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register with built-in load-use hazard detection for the 5-stage RISC-V core. It sits directly downstream of the decode-stage control decoder. Each cycle it captures that decoder's control bits together with the decoded operands. It inserts exactly one bubble when the instruction in ID needs the result of a load still in EX, and it holds its contents while the memory stage stalls.

## Interface
Parameters:
- `CNT_W`, 32, width of the saturating bubble counter.

Ports:
- `clk_i`  in  1  clock; all state updates on its rising edge.
- `rst_i`  in  1  asynchronous, active-low reset.
- `mem_stall_i`  in  1  memory-stage stall; holds this register.
- `MemWrite_i, MemRead_i, MemToReg_i, ALUSrc_i, RegWrite_i`  in  1 each  decode control bits.
- `ALUOp_i`  in  2  decode ALU op class.
- `RS1data_i, RS2data_i, Imm_i`  in  32 each  register-file reads and immediate.
- `Funct_i`  in  10  {funct7, funct3}.
- `RS1addr_i, RS2addr_i, RDaddr_i`  in  5 each  register indices of the ID instruction.
- `MemWrite_o, MemRead_o, MemToReg_o, ALUSrc_o, RegWrite_o`  out  1 each  registered control bits.
- `ALUOp_o`  out  2  registered ALU op class.
- `RS1data_o, RS2data_o, Imm_o`  out  32 each  registered data.
- `Funct_o`  out  10  registered funct field.
- `RS1addr_o, RS2addr_o, RDaddr_o`  out  5 each  registered indices, consumed by forwarding.
- `Stall_o`  out  1  load-use hazard; IF/ID must hold.
- `PCWrite_o`  out  1  equals ~Stall_o; PC may advance.
- `bubble_cnt_o`  out  CNT_W  count of bubbles inserted.

## Operation
- The hazard is combinational from registered state plus the ID inputs: hazard = MemRead_o & (RDaddr_o != 0) & ((RDaddr_o == RS1addr_i) | (use_rs2 & (RDaddr_o == RS2addr_i))).
- use_rs2 = ~ALUSrc_i | MemWrite_i. This covers R-type, branch and store.
- `Stall_o` equals hazard and does not depend on `mem_stall_i`.
- Register update priority at each edge:
  - If `mem_stall_i`=1: hold every register, including the counter.
  - Else if hazard: load a bubble. All seven control bits go to 0; data, funct and address fields load normally (don't-care). `bubble_cnt_o` increments, saturating at all-ones.
  - Else: load all inputs unchanged.
- Because a bubble clears MemRead, the hazard drops in the following cycle. One load therefore produces at most one bubble.
- Register x0 never causes a hazard.
- There is no branch flush input. Flushing of the wrong-path instruction happens upstream at IF/ID.

## Timing
- Latency is 1 cycle, input to output.
- Reset (asynchronous, `rst_i`=0):
  - All registered outputs are 0 and `bubble_cnt_o`=0.
  - As a result, `Stall_o`=0 and `PCWrite_o`=1.
  - Reset asserted mid-stall clears state immediately.
  - The first edge after release loads normally.
- Load-use sequence:
  - Cycle N: the load is in ID/EX (`MemRead_o`=1, `RDaddr_o`=5) and the consumer is in ID with rs1=5. `Stall_o`=1.
  - Edge N→N+1: the bubble is loaded.
  - Cycle N+1: `Stall_o`=0.
  - Edge N+1→N+2: the consumer enters ID/EX.
- Simultaneous hazard and `mem_stall_i`: the register holds and `Stall_o` stays 1. The bubble is inserted on the first edge where `mem_stall_i`=0, and the counter increments only then.
- A back-to-back load followed by a dependent load still gives one bubble per dependency.

## Test plan
- **Reset:** drive `rst_i`=0 mid-cycle with nonzero inputs -> all outputs 0 immediately, `PCWrite_o`=1, `bubble_cnt_o`=0.
- **Pass-through:** R-type `add x3,x1,x2` (ALUOp=10, RegWrite=1, RS1data=0x11, RS2data=0x22) -> same values on the outputs one edge later, `Stall_o`=0.
- **Load-use:**
  - Stimulus: `lw x5` in EX, then `add x6,x5,x7` in ID.
  - Required: `Stall_o`=1 for exactly 1 cycle; next-cycle outputs are all-zero control; `add` appears the cycle after; `bubble_cnt_o`=1.
- **rs2 gating and x0:**
  - `lw x5` followed by `addi x6,x1,5` with rs2 field=5 and ALUSrc=1 -> no stall.
  - `sw x5,0(x1)` with rs2=5 -> stall.
  - `lw x0` followed by a consumer of x0 -> no stall.
- **Memory stall overlap:** hold `mem_stall_i`=1 for 3 cycles during a load-use hazard -> outputs frozen, `Stall_o`=1 throughout, the bubble appears on the edge after release, and the counter increments by exactly 1.
- **Saturation:** build with `CNT_W`=2 and force 5 bubbles -> `bubble_cnt_o` stops at 3.
